mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto a multi-cycle data-memory handshake.
- Generates the word-aligned address, byte enables and lane-replicated store data.
- Extracts and sign- or zero-extends the selected byte or half-word of load data.
- Stalls the pipeline while an access is outstanding, and reports misaligned-address and bus-timeout errors to the exception logic.

Parameters:
- TIMEOUT, 16: maximum number of ACCESS cycles before an abort with bus_err. A value of 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  the MEM-stage instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  freezes the pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result.
- addr_err  out  1  misaligned or reserved-size request; valid with done.
- bus_err  out  1  timeout abort; valid with done.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables; bit i = byte lane i (bits 8i+7:8i).
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  raw load word.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers cleared.
  - stall, done, addr_err, bus_err, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0.
  - A reset during ACCESS drops mem_req immediately; no done pulse is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req_valid=1:
  - Latch addr, size, we, unsigned and wdata.
  - Aligned request: go to ACCESS.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size=3): go to RESP with addr_err set; no memory access is made.
- ACCESS:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are driven from the latched registers and held stable until mem_ack.
  - On mem_ack: register the extended rdata for loads only (stores leave rdata unchanged), then go to RESP.
  - Timeout: the counter increments in each ACCESS cycle. If TIMEOUT cycles elapse without mem_ack, drop mem_req, set bus_err and go to RESP.
  - mem_ack in the final timeout cycle counts as a normal completion; ack wins over timeout.
- RESP: done=1 for one cycle; then unconditionally go to IDLE. A new request is not accepted in RESP, because req_valid still shows the same instruction.
- stall = (IDLE & req_valid) | ACCESS. stall is 0 in RESP, which lets the pipeline advance at the end of that cycle.
- addr_err and bus_err are asserted only in RESP and are cleared on the next accept.
- rdata holds its value until the next load completes.
- mem_ack outside ACCESS is ignored.
- Byte enables:
  - byte: 1 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lane addr[1] (0 = bits 15:0, 1 = bits 31:16).
  - Extension: sign-extend when req_unsigned=0, zero-extend when req_unsigned=1.
  - Word loads pass through unchanged.
- Minimum latency with ack in the first ACCESS cycle: accept (stall) → ACCESS (stall) → RESP (done). That is 2 stall cycles; an ack after k ACCESS cycles gives 1+k stall cycles.

Test Plan:
- Word load at 0x0000_0100, mem_ack in the 2nd ACCESS cycle with mem_rdata 0xDEADBEEF → mem_addr 0x100, mem_be 4'b1111, stall high 3 cycles, done pulse, rdata 0xDEADBEEF.
- Half loads with mem_rdata 0x8001_1234:
  - signed at 0x102 → rdata 0xFFFF_8001.
  - unsigned at 0x102 → 0x0000_8001.
  - signed at 0x100 → 0x0000_1234.
- Signed byte load at 0x001, mem_rdata 0x0000_8000 → mem_be 4'b0010, rdata 0xFFFF_FF80; the same access unsigned → 0x0000_0080.
- Byte store at 0x203 with wdata 0x0000_00A5 → mem_addr 0x200, mem_we 1, mem_be 4'b1000, mem_wdata 0xA5A5_A5A5; rdata unchanged from the previous load.
- Word load at 0x102 → mem_req stays 0, stall for 1 cycle, done and addr_err together for 1 cycle. Repeat with size=3 → same response.
- TIMEOUT=4, no ack → mem_req high exactly 4 cycles, then done and bus_err. Separately, assert rst_n=0 during ACCESS → mem_req and stall fall immediately, and no done pulse follows reset release.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Data-memory handshake between the MEM-stage access controller and the
// data memory (or its bus adapter).
//
//   mem_req    controller -> memory   request is active
//   mem_we     controller -> memory   1 = write, 0 = read
//   mem_addr   controller -> memory   word-aligned byte address
//   mem_be     controller -> memory   byte enables, bit i = bits 8i+7:8i
//   mem_wdata  controller -> memory   lane-replicated write data
//   mem_ack    memory -> controller   access complete this cycle
//   mem_rdata  memory -> controller   raw read word, valid with mem_ack
//
// Modports: master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequences MEM-stage loads and stores onto a multi-cycle data-memory
// handshake. Builds the word address, byte enables and lane-replicated store
// data, extracts and extends load data, stalls the pipeline while an access
// is outstanding and reports misaligned-address / bus-timeout errors.
//
// Parameters
//   TIMEOUT       max ACCESS cycles before abort with bus_err (0 = no limit)
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     MEM-stage instruction is a load or store
//   req_we        1 = store, 0 = load
//   req_size      0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned  zero-extend loads (LBU/LHU)
//   req_addr      effective byte address
//   req_wdata     store data, right-justified
//   stall         freezes the pipeline
//   done          one-cycle completion pulse
//   rdata         extended load result (held until the next load completes)
//   addr_err      misaligned / reserved-size request, valid with done
//   bus_err       timeout abort, valid with done
//   mem           data-memory handshake (master side)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  addr_err,
  output logic                  bus_err,
  mem_access_ctrl_if.master     mem
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // The counter only ever needs to reach TIMEOUT-1: the cycle in which it
  // equals that value is the last one allowed to wait for mem_ack.
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic             we_q;
  logic             uns_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             addr_err_q;
  logic             bus_err_q;
  logic [31:0]      rdata_q;

  logic             in_idle;
  logic             in_access;
  logic             in_resp;
  logic             misaligned;
  logic             timeout_hit;
  logic [3:0]       be;
  logic [31:0]      lane_wdata;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_val;

  assign in_idle   = (state == S_IDLE);
  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  // Alignment is judged on the incoming request so the accept cycle can
  // route straight to RESP without touching memory.
  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    misaligned = 1'b1;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Byte enables and lane-replicated store data from the latched request.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Load lane selection and sign/zero extension of the raw memory word.
  always_comb begin
    load_byte = mem.mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    load_byte = mem.mem_rdata[7:0];
      2'd1:    load_byte = mem.mem_rdata[15:8];
      2'd2:    load_byte = mem.mem_rdata[23:16];
      default: load_byte = mem.mem_rdata[31:24];
    endcase
    load_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    load_val = mem.mem_rdata;
    case (size_q)
      SZ_BYTE: load_val = {{24{~uns_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_val = {{16{~uns_q & load_half[15]}}, load_half};
      default: load_val = mem.mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            wdata_q    <= req_wdata;
            cnt        <= '0;
            addr_err_q <= misaligned;
            bus_err_q  <= 1'b0;
            state      <= misaligned ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          // An ack in the last allowed cycle is checked first, so it
          // completes normally instead of timing out.
          if (mem.mem_ack) begin
            if (!we_q) rdata_q <= load_val;
            state <= S_RESP;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          // req_valid still shows the instruction just completed, so no new
          // request can be taken here.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // rst_n also gates the accept term: with the FSM forced to IDLE, a still
  // asserted req_valid must not raise stall while reset is held.
  assign stall    = rst_n & ((in_idle & req_valid) | in_access);
  assign done     = in_resp;
  assign addr_err = in_resp & addr_err_q;
  assign bus_err  = in_resp & bus_err_q;
  assign rdata    = rdata_q;

  // Bus outputs are quiet outside ACCESS and held stable while in it.
  assign mem.mem_req   = in_access;
  assign mem.mem_we    = in_access & we_q;
  assign mem.mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem.mem_be    = in_access ? be : 4'd0;
  assign mem.mem_wdata = in_access ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Drives directed and randomized loads/stores into mem_access_ctrl, plays the
// memory side with a planned ack delay per access, and compares every DUT
// output against expectations built from the access plan once per cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;

  mem_access_ctrl_if mem_bus ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .addr_err     (addr_err),
    .bus_err      (bus_err),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle expectations, set just after each rising edge.
  bit          check_en = 1'b0;
  logic        exp_stall, exp_done, exp_addr_err, exp_bus_err;
  logic        exp_mem_req, exp_mem_we;
  logic [31:0] exp_mem_addr, exp_mem_wdata;
  logic [3:0]  exp_mem_be;
  logic [31:0] model_rdata = 32'd0;
  int          req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("stall",    {31'd0, stall},    {31'd0, exp_stall});
      check("done",     {31'd0, done},     {31'd0, exp_done});
      check("addr_err", {31'd0, addr_err}, {31'd0, exp_addr_err});
      check("bus_err",  {31'd0, bus_err},  {31'd0, exp_bus_err});
      check("mem_req",  {31'd0, mem_bus.mem_req}, {31'd0, exp_mem_req});
      check("rdata",    rdata, model_rdata);
      if (exp_mem_req) begin
        check("mem_we",    {31'd0, mem_bus.mem_we}, {31'd0, exp_mem_we});
        check("mem_addr",  mem_bus.mem_addr, exp_mem_addr);
        check("mem_be",    {28'd0, mem_bus.mem_be}, {28'd0, exp_mem_be});
        check("mem_wdata", mem_bus.mem_wdata, exp_mem_wdata);
      end
      if (mem_bus.mem_req) req_cycles++;
    end
  end

  // Reference load result: shift the addressed lane down, mask, then extend.
  function automatic logic [31:0] ext_load(input logic [31:0] raw, input logic [31:0] addr,
                                           input logic [1:0] size, input bit uns);
    logic [31:0] v;
    case (size)
      2'd0: begin
        v = (raw >> (8 * addr[1:0])) & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (raw >> (16 * addr[1])) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 4'(1 << addr[1:0]);
      2'd1:    return addr[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  // Replication expressed as multiplication by a lane-spreading constant.
  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet_exp();
    exp_stall    = 1'b0;
    exp_done     = 1'b0;
    exp_addr_err = 1'b0;
    exp_bus_err  = 1'b0;
    exp_mem_req  = 1'b0;
    exp_mem_we   = 1'b0;
    exp_mem_addr = 32'd0;
    exp_mem_be   = 4'd0;
    exp_mem_wdata = 32'd0;
  endtask

  // Idle cycles with random noise on the memory side, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid         = 1'b0;
      req_addr          = $urandom;
      req_wdata         = $urandom;
      mem_bus.mem_ack   = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata = $urandom;
      set_quiet_exp();
      tick();
    end
  endtask

  // One complete request. ack_k is the ACCESS cycle (1-based) carrying
  // mem_ack; a value above TIMEOUT means the memory never answers.
  task automatic txn(input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int ack_k, input logic [31:0] rword);
    bit mis;
    bit to;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    to  = 1'b0;

    // Accept cycle.
    req_valid         = 1'b1;
    req_we            = we;
    req_size          = size;
    req_unsigned      = uns;
    req_addr          = addr;
    req_wdata         = wdata;
    mem_bus.mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    set_quiet_exp();
    exp_stall = 1'b1;
    tick();

    if (!mis) begin
      for (int i = 1; i <= int'(TIMEOUT) + ack_k; i++) begin
        set_quiet_exp();
        exp_stall     = 1'b1;
        exp_mem_req   = 1'b1;
        exp_mem_we    = we;
        exp_mem_addr  = addr & ~32'd3;
        exp_mem_be    = ref_be(size, addr);
        exp_mem_wdata = ref_wdata(size, wdata);
        mem_bus.mem_ack   = (i == ack_k);
        mem_bus.mem_rdata = (i == ack_k) ? rword : $urandom;
        tick();
        if (i == ack_k) begin
          if (!we) model_rdata = ext_load(rword, addr, size, uns);
          break;
        end
        if (TIMEOUT != 0 && i == int'(TIMEOUT)) begin
          to = 1'b1;
          break;
        end
      end
    end

    // Response cycle: instruction still presented, pipeline released.
    mem_bus.mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    set_quiet_exp();
    exp_done     = 1'b1;
    exp_addr_err = mis;
    exp_bus_err  = to;
    tick();
  endtask

  int r0;

  initial begin
    req_valid         = 1'b0;
    req_we            = 1'b0;
    req_size          = 2'd0;
    req_unsigned      = 1'b0;
    req_addr          = 32'd0;
    req_wdata         = 32'd0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    set_quiet_exp();

    // Reset state, including a request presented while reset is held.
    #12;
    req_valid = 1'b1;
    #1;
    check("rst stall",     {31'd0, stall},    32'd0);
    check("rst done",      {31'd0, done},     32'd0);
    check("rst addr_err",  {31'd0, addr_err}, 32'd0);
    check("rst bus_err",   {31'd0, bus_err},  32'd0);
    check("rst mem_req",   {31'd0, mem_bus.mem_req}, 32'd0);
    check("rst mem_we",    {31'd0, mem_bus.mem_we},  32'd0);
    check("rst mem_addr",  mem_bus.mem_addr, 32'd0);
    check("rst mem_be",    {28'd0, mem_bus.mem_be}, 32'd0);
    check("rst mem_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst rdata",     rdata, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    idle(2);

    // Word load, ack in 2nd ACCESS cycle.
    r0 = req_cycles;
    txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 2, 32'hDEAD_BEEF);
    check("word load rdata", rdata, 32'hDEAD_BEEF);
    check("word load req cycles", 32'(req_cycles - r0), 32'd2);
    idle(1);

    // Half loads.
    txn(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'd0, 1, 32'h8001_1234);
    check("lh 0x102", rdata, 32'hFFFF_8001);
    txn(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 3, 32'h8001_1234);
    check("lhu 0x102", rdata, 32'h0000_8001);
    txn(1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'd0, 1, 32'h8001_1234);
    check("lh 0x100", rdata, 32'h0000_1234);

    // Byte loads.
    txn(1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'd0, 1, 32'h0000_8000);
    check("lb 0x001", rdata, 32'hFFFF_FF80);
    txn(1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'd0, 2, 32'h0000_8000);
    check("lbu 0x001", rdata, 32'h0000_0080);

    // Byte store leaves rdata alone.
    txn(1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 1, 32'h1234_5678);
    check("sb keeps rdata", rdata, 32'h0000_0080);
    idle(1);

    // Misaligned word and reserved size: no memory traffic.
    r0 = req_cycles;
    txn(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 1, 32'hFFFF_FFFF);
    txn(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'd0, 1, 32'hFFFF_FFFF);
    check("misaligned req cycles", 32'(req_cycles - r0), 32'd0);

    // Timeout, then ack exactly in the final allowed cycle.
    r0 = req_cycles;
    txn(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0, int'(TIMEOUT) + 1, 32'd0);
    check("timeout req cycles", 32'(req_cycles - r0), 32'(TIMEOUT));
    txn(1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'd0, int'(TIMEOUT), 32'h0BAD_F00D);
    check("last-cycle ack rdata", rdata, 32'h0BAD_F00D);
    idle(1);

    // Reset while ACCESS is outstanding.
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_0100;
    mem_bus.mem_ack = 1'b0;
    set_quiet_exp();
    exp_stall = 1'b1;
    tick();
    check_en = 1'b0;
    #2;
    check("pre-reset mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("reset mem_req drop", {31'd0, mem_bus.mem_req}, 32'd0);
    check("reset stall drop",   {31'd0, stall}, 32'd0);
    check("reset rdata clear",  rdata, 32'd0);
    model_rdata = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(1, int'(TIMEOUT) + 1), $urandom);
      idle($urandom_range(0, 2));
    end

    idle(1);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
